// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite palette bank: colour struct,
// flash state encoding and the power-up palette table.
package sprite_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  typedef enum logic {
    IDLE,
    FLASH
  } state_t;

  localparam int DEFAULT_PAL_LEN = 16;

  localparam rgb_t DEFAULT_PAL [DEFAULT_PAL_LEN] = '{
    12'h000, 12'hFFF, 12'hF00, 12'h0F0,
    12'h00F, 12'hFF0, 12'h0FF, 12'hF0F,
    12'h888, 12'h444, 12'hC60, 12'h6C0,
    12'h06C, 12'hC06, 12'h963, 12'h369
  };

  // Select-field width for a palette count; a single palette still needs one bit.
  function automatic int pal_width(input int num_pal);
    return (num_pal > 1) ? $clog2(num_pal) : 1;
  endfunction

endpackage

// File: rtl/palette_flash_fsm.sv
// Frame-counted flash effect: latches a frame count, counts frame ticks down
// and flags the frames on which lookups should be forced to white.
module palette_flash_fsm
  import sprite_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       flash_start,
  input  logic [7:0] flash_frames,
  output logic       flash_busy,
  output logic       flash_white
);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the combinational block below uses blocking ones.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // NOTE: defaults first so no path leaves a target unassigned (no latches).
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (flash_start && (flash_frames != 8'd0)) begin
          cnt_nx   = flash_frames - {7'd0, frame_tick};
          state_nx = (cnt_nx != 8'd0) ? FLASH : IDLE;
        end
      end
      FLASH: begin
        if (frame_tick) begin
          cnt_nx = cnt - 8'd1;
          if (cnt_nx == 8'd0) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign flash_busy  = (state == FLASH);
  assign flash_white = flash_busy && cnt[0];

endmodule

// File: rtl/sprite_palette_bank.sv
// Multi-palette colour lookup with one-cycle registered output.
// Optional frame-based white flash effect enabled by SPRITE_PALETTE_FLASH_EN.
module sprite_palette_bank
  import sprite_pkg::*;
#(
  parameter  int NUM_PAL = 4,
  parameter  int IDX_W   = 4,
  parameter  int CH_W    = 4,
  localparam int PAL_W   = pal_width(NUM_PAL),
  localparam int RGB_W   = 3 * CH_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             rd_valid,
  input  logic [PAL_W-1:0] rd_pal,
  input  logic [IDX_W-1:0] rd_index,
  input  logic             wr_en,
  input  logic [PAL_W-1:0] wr_pal,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [RGB_W-1:0] wr_rgb,
  input  logic             frame_tick,
  input  logic             flash_start,
  input  logic [7:0]       flash_frames,
  output logic             out_valid,
  output logic [CH_W-1:0]  red,
  output logic [CH_W-1:0]  green,
  output logic [CH_W-1:0]  blue,
  output logic             transparent,
  output logic             flash_busy
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic [RGB_W-1:0] mem [NUM_PAL][ENTRIES];
  logic [RGB_W-1:0] rgb_q;
  logic [PAL_W-1:0] rd_p, wr_p;
  logic             white;

  // The power-up table repeats every 16 entries and is resized per channel.
  function automatic logic [RGB_W-1:0] default_entry(input int idx);
    rgb_t d;
    d = DEFAULT_PAL[idx % DEFAULT_PAL_LEN];
    return {CH_W'(d.r), CH_W'(d.g), CH_W'(d.b)};
  endfunction

  // A single-palette build carries a 1-bit select that must not index past row 0.
  assign rd_p = (NUM_PAL > 1) ? rd_pal : '0;
  assign wr_p = (NUM_PAL > 1) ? wr_pal : '0;

  // NOTE: the palette array is reset on purpose, because Reset must restore
  // the default colours; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int p = 0; p < NUM_PAL; p++) begin
        for (int i = 0; i < ENTRIES; i++) begin
          mem[p][i] <= default_entry(i);
        end
      end
    end else if (wr_en) begin
      mem[wr_p][wr_index] <= wr_rgb;
    end
  end

  // The array is read before the edge, so a colliding write yields the old entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid   <= 1'b0;
      rgb_q       <= '0;
      transparent <= 1'b0;
    end else begin
      out_valid <= rd_valid;
      if (rd_valid) begin
        transparent <= (rd_index == '0);
        rgb_q       <= (white && (rd_index != '0)) ? '1 : mem[rd_p][rd_index];
      end
    end
  end

  assign {red, green, blue} = rgb_q;

`ifdef SPRITE_PALETTE_FLASH_EN
  palette_flash_fsm u_flash (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .flash_start  (flash_start),
    .flash_frames (flash_frames),
    .flash_busy   (flash_busy),
    .flash_white  (white)
  );
`else
  logic unused_flash;
  assign unused_flash = ^{frame_tick, flash_start, flash_frames};
  assign white        = 1'b0;
  assign flash_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Scoreboard bench for sprite_palette_bank: directed lookups, writes,
// collisions, reset priority and (when built in) the flash effect.
module tb_sprite_palette_bank;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        rd_valid;
  logic [1:0]  rd_pal;
  logic [3:0]  rd_index;
  logic        wr_en;
  logic [1:0]  wr_pal;
  logic [3:0]  wr_index;
  logic [11:0] wr_rgb;
  logic        frame_tick;
  logic        flash_start;
  logic [7:0]  flash_frames;
  logic        out_valid;
  logic [3:0]  red, green, blue;
  logic        transparent;
  logic        flash_busy;

  typedef struct {
    logic [11:0] rgb;
    logic        transp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 Clk = ~Clk;

  sprite_palette_bank dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .rd_valid     (rd_valid),
    .rd_pal       (rd_pal),
    .rd_index     (rd_index),
    .wr_en        (wr_en),
    .wr_pal       (wr_pal),
    .wr_index     (wr_index),
    .wr_rgb       (wr_rgb),
    .frame_tick   (frame_tick),
    .flash_start  (flash_start),
    .flash_frames (flash_frames),
    .out_valid    (out_valid),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .transparent  (transparent),
    .flash_busy   (flash_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid result is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check(e.tag, {20'd0, red, green, blue}, {20'd0, e.rgb});
          check({e.tag, "_transp"}, {31'd0, transparent}, {31'd0, e.transp});
        end
      end
    end
  end

  task automatic rd(input int pal, input int idx, input logic [11:0] exp_rgb,
                    input logic exp_tr, input string tag);
    rd_valid = 1'b1;
    rd_pal   = pal[1:0];
    rd_index = idx[3:0];
    sb.push_back('{rgb: exp_rgb, transp: exp_tr, tag: tag});
    @(negedge Clk);
    rd_valid = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  task automatic start_flash(input logic [7:0] frames, input logic with_tick);
    flash_start  = 1'b1;
    flash_frames = frames;
    frame_tick   = with_tick;
    @(negedge Clk);
    flash_start  = 1'b0;
    frame_tick   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1; rd_valid = 1'b1; rd_pal = 2'd0; rd_index = 4'd1;
    wr_en = 1'b1; wr_pal = 2'd0; wr_index = 4'd1; wr_rgb = 12'h123;
    frame_tick = 1'b0; flash_start = 1'b1; flash_frames = 8'd3;
    repeat (3) @(negedge Clk);
    // Reset held against read/write/flash requests: all outputs must be cleared.
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rgb", {20'd0, red, green, blue}, 32'd0);
    check("rst_transparent", {31'd0, transparent}, 32'd0);
    check("rst_flash_busy", {31'd0, flash_busy}, 32'd0);
    Reset = 1'b0; rd_valid = 1'b0; wr_en = 1'b0; flash_start = 1'b0;

    rd(0, 1, 12'hFFF, 1'b0, "p0_i1_default");
    rd(0, 2, 12'hF00, 1'b0, "p0_i2_default");
    rd(3, 15, 12'h369, 1'b0, "p3_i15_default");
    rd(1, 10, 12'hC60, 1'b0, "p1_i10_default");
    rd(1, 0, 12'h000, 1'b1, "p1_i0_transp");

    // Index 0 stays transparent whatever colour it holds.
    wr_en = 1'b1; wr_pal = 2'd3; wr_index = 4'd0; wr_rgb = 12'h5A5;
    @(negedge Clk);
    wr_en = 1'b0;
    rd(3, 0, 12'h5A5, 1'b1, "p3_i0_written_transp");

    // Same-cycle read of the entry being written returns the old value.
    wr_en = 1'b1; wr_pal = 2'd2; wr_index = 4'd5; wr_rgb = 12'h3A7;
    rd(2, 5, 12'hFF0, 1'b0, "p2_i5_collide_old");
    wr_en = 1'b0;
    rd(2, 5, 12'h3A7, 1'b0, "p2_i5_new");
    rd(1, 5, 12'hFF0, 1'b0, "p1_i5_untouched");

    // With rd_valid low the colour holds and out_valid drops.
    @(negedge Clk);
    check("hold_out_valid", {31'd0, out_valid}, 32'd0);
    check("hold_rgb", {20'd0, red, green, blue}, 32'h0FF0);

`ifdef SPRITE_PALETTE_FLASH_EN
    start_flash(8'd0, 1'b0);
    check("flash_zero_idle", {31'd0, flash_busy}, 32'd0);

    start_flash(8'd4, 1'b0);
    check("flash4_busy_c4", {31'd0, flash_busy}, 32'd1);
    rd(2, 5, 12'h3A7, 1'b0, "flash_c4_plain");
    tick();
    rd(2, 5, 12'hFFF, 1'b0, "flash_c3_white");
    rd(2, 0, 12'h000, 1'b1, "flash_c3_transp_unforced");
    start_flash(8'd9, 1'b0);
    rd(2, 5, 12'hFFF, 1'b0, "flash_restart_ignored");
    tick();
    check("flash4_busy_c2", {31'd0, flash_busy}, 32'd1);
    rd(2, 5, 12'h3A7, 1'b0, "flash_c2_plain");
    tick();
    check("flash4_busy_c1", {31'd0, flash_busy}, 32'd1);
    rd(2, 5, 12'hFFF, 1'b0, "flash_c1_white");
    tick();
    check("flash4_idle_after", {31'd0, flash_busy}, 32'd0);
    rd(2, 5, 12'h3A7, 1'b0, "flash_done_plain");

    // Start coinciding with a frame tick counts from frames-1.
    start_flash(8'd2, 1'b1);
    check("flash_tick_start_busy", {31'd0, flash_busy}, 32'd1);
    rd(2, 5, 12'hFFF, 1'b0, "flash_tick_start_white");
    tick();
    check("flash_tick_start_idle", {31'd0, flash_busy}, 32'd0);

    start_flash(8'd6, 1'b0);
    check("flash6_busy", {31'd0, flash_busy}, 32'd1);
`else
    start_flash(8'd4, 1'b0);
    check("noflash_busy_start", {31'd0, flash_busy}, 32'd0);
    rd(2, 5, 12'h3A7, 1'b0, "noflash_c4_plain");
    tick();
    rd(2, 5, 12'h3A7, 1'b0, "noflash_c3_plain");
    tick();
    check("noflash_busy_ticks", {31'd0, flash_busy}, 32'd0);
    start_flash(8'd6, 1'b0);
`endif

    // Reset with a concurrent write and read: write dropped, flash aborted.
    Reset = 1'b1; wr_en = 1'b1; wr_pal = 2'd2; wr_index = 4'd5; wr_rgb = 12'h123;
    rd_valid = 1'b1; rd_pal = 2'd2; rd_index = 4'd5;
    @(negedge Clk);
    Reset = 1'b0; wr_en = 1'b0; rd_valid = 1'b0;
    check("rst2_flash_busy", {31'd0, flash_busy}, 32'd0);
    check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    rd(2, 5, 12'hFF0, 1'b0, "rst2_p2_i5_default");
    rd(3, 0, 12'h000, 1'b1, "rst2_p3_i0_default");

    repeat (2) @(negedge Clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
